multi_flex_counter: RTL and testbench

//  Parametrised multi-channel successor of the team's flexible counter.
//  NUM_CHANNELS independent counters, each with its own rollover value, clear, parallel load and mode (wrap / one-shot).

---
 rtl/flex_cnt_pkg.sv | 14 +
 rtl/flex_cnt_channel.sv | 86 ++++++++
 rtl/multi_flex_counter.sv | 69 ++++++
 tb/tb_multi_flex_counter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/flex_cnt_pkg.sv
// Shared types and limits for the multi-channel flexible counter.
package flex_cnt_pkg;

    // Per-channel counting behaviour once the terminal value is met.
    typedef enum logic {
        CNT_WRAP    = 1'b0,
        CNT_ONESHOT = 1'b1
    } cnt_mode_t;

    localparam int MIN_CHANNELS = 1;
    localparam int MAX_CHANNELS = 16;
    localparam int MIN_CNT_BITS = 2;

endpackage : flex_cnt_pkg

// File: rtl/flex_cnt_channel.sv
// One flexible counter channel: count register, one-shot halted bit and a
// registered wrap pulse. tick_o marks an enabled, non-halted cycle at the
// terminal value and feeds the next channel when channels are cascaded.
module flex_cnt_channel
    import flex_cnt_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  cnt_mode_t    mode_i,
    input  logic [W-1:0] rollover_val_i,
    output logic [W-1:0] count_o,
    output logic         rollover_flag_o,
    output logic         wrap_pulse_o,
    output logic         tick_o
);

    logic [W-1:0] count_q, count_d;
    logic         halted_q, halted_d;
    logic         pulse_q, pulse_d;
    logic [W-1:0] count_inc;
    logic         r_zero;
    logic         at_or_past_r;

    assign count_inc    = count_q + W'(1);
    assign r_zero       = (rollover_val_i == '0);
    assign at_or_past_r = (count_q >= rollover_val_i);

    // Next count / halted / pulse; priority clear > load > enable > hold.
    always_comb begin
        count_d  = count_q;
        halted_d = halted_q;
        pulse_d  = 1'b0;
        if (clear_i) begin
            count_d  = '0;
            halted_d = 1'b0;
        end else if (load_i) begin
            count_d  = load_val_i;
            halted_d = 1'b0;
        end else if (en_i && !halted_q) begin
            if (r_zero) begin
                // A zero terminal value parks the channel at 0.
                count_d = '0;
            end else if (at_or_past_r) begin
                // Checked before incrementing, so the count never overflows.
                if (mode_i == CNT_WRAP) begin
                    count_d = W'(1);
                end else begin
                    halted_d = 1'b1;
                end
            end else begin
                count_d = count_inc;
                if (count_inc == rollover_val_i) begin
                    pulse_d = 1'b1;
                    if (mode_i == CNT_ONESHOT) begin
                        halted_d = 1'b1;
                    end
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            halted_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            halted_q <= halted_d;
            pulse_q  <= pulse_d;
        end
    end

    assign count_o         = count_q;
    assign wrap_pulse_o    = pulse_q;
    assign rollover_flag_o = !r_zero && (count_q == rollover_val_i);
    assign tick_o          = en_i && !halted_q && !r_zero && at_or_past_r;

endmodule : flex_cnt_channel

// File: rtl/multi_flex_counter.sv
// Multi-channel flexible counter: NUM_CHANNELS independent flex_cnt_channel
// instances sharing one clock and reset.
// Optional feature macro: FLEX_CNT_CASCADE_EN -- when defined, channel c>0
// only counts on cycles where channel c-1 ticks at its terminal value, so the
// channels form one wide prescaled counter.
module multi_flex_counter
    import flex_cnt_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CHANNELS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CHANNELS-1:0]          clear,
    input  logic [NUM_CHANNELS-1:0]          load,
    input  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CHANNELS-1:0]          count_enable,
    input  logic [NUM_CHANNELS-1:0]          mode,
    input  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_CHANNELS-1:0]          rollover_flag,
    output logic [NUM_CHANNELS-1:0]          wrap_pulse,
    output logic                             any_rollover
);

    localparam int W = NUM_CNT_BITS;

    logic [NUM_CHANNELS-1:0] term_tick;
    logic                    unused_tick;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : ch_g
        logic en_c;
        logic tick_c;

`ifdef FLEX_CNT_CASCADE_EN
        if (c == 0) begin : en_first_g
            assign en_c = count_enable[c];
        end else begin : en_chain_g
            assign en_c = count_enable[c] & ch_g[c-1].tick_c;
        end
`else
        assign en_c = count_enable[c];
`endif

        flex_cnt_channel #(
            .W (W)
        ) u_channel (
            .clk             (clk),
            .rst             (rst),
            .clear_i         (clear[c]),
            .load_i          (load[c]),
            .load_val_i      (load_val[c*W +: W]),
            .en_i            (en_c),
            .mode_i          (cnt_mode_t'(mode[c])),
            .rollover_val_i  (rollover_val[c*W +: W]),
            .count_o         (count_out[c*W +: W]),
            .rollover_flag_o (rollover_flag[c]),
            .wrap_pulse_o    (wrap_pulse[c]),
            .tick_o          (tick_c)
        );

        assign term_tick[c] = tick_c;
    end

    // The last channel's tick (and all ticks without cascading) go nowhere.
    assign unused_tick  = ^term_tick;
    assign any_rollover = |rollover_flag;

endmodule : multi_flex_counter

// File: tb/tb_multi_flex_counter.sv
// Self-checking bench for multi_flex_counter: directed scenarios plus random
// traffic, all compared against a behavioural per-channel model.
module tb_multi_flex_counter;

    localparam int W   = 4;
    localparam int NCH = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NCH-1:0]     clear, load, count_enable, mode;
    logic [NCH*W-1:0]   load_val, rollover_val;
    logic [NCH*W-1:0]   count_out;
    logic [NCH-1:0]     rollover_flag, wrap_pulse;
    logic               any_rollover;

    int  n_total = 0;
    int  n_bad   = 0;

    int  m_cnt   [NCH];
    bit  m_halt  [NCH];
    bit  m_pulse [NCH];

    multi_flex_counter #(
        .NUM_CNT_BITS (W),
        .NUM_CHANNELS (NCH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .load          (load),
        .load_val      (load_val),
        .count_enable  (count_enable),
        .mode          (mode),
        .rollover_val  (rollover_val),
        .count_out     (count_out),
        .rollover_flag (rollover_flag),
        .wrap_pulse    (wrap_pulse),
        .any_rollover  (any_rollover)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Behavioural model: advance every channel by one clock edge.
    task automatic model_edge();
`ifdef FLEX_CNT_CASCADE_EN
        bit prev_tick = 1'b0;
`endif
        for (int c = 0; c < NCH; c++) begin
            int r;
            bit en;
            r  = int'(rollover_val[c*W +: W]);
            en = count_enable[c];
`ifdef FLEX_CNT_CASCADE_EN
            if (c > 0) en = en & prev_tick;
            prev_tick = en && !m_halt[c] && r != 0 && m_cnt[c] >= r;
`endif
            m_pulse[c] = 1'b0;
            if (rst) begin
                m_cnt[c]  = 0;
                m_halt[c] = 1'b0;
            end else if (clear[c]) begin
                m_cnt[c]  = 0;
                m_halt[c] = 1'b0;
            end else if (load[c]) begin
                m_cnt[c]  = int'(load_val[c*W +: W]);
                m_halt[c] = 1'b0;
            end else if (en && !m_halt[c]) begin
                if (r == 0) begin
                    m_cnt[c] = 0;
                end else if (m_cnt[c] >= r) begin
                    if (mode[c]) m_halt[c] = 1'b1;
                    else         m_cnt[c]  = 1;
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                    if (m_cnt[c] == r) begin
                        m_pulse[c] = 1'b1;
                        if (mode[c]) m_halt[c] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        bit any_exp = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            int r;
            bit flag_exp;
            r        = int'(rollover_val[c*W +: W]);
            flag_exp = (r != 0) && (m_cnt[c] == r);
            any_exp  = any_exp | flag_exp;
            check_eq($sformatf("count%0d", c), 32'(count_out[c*W +: W]), 32'(m_cnt[c]));
            check_eq($sformatf("flag%0d", c), 32'(rollover_flag[c]), 32'(flag_exp));
            check_eq($sformatf("pulse%0d", c), 32'(wrap_pulse[c]), 32'(m_pulse[c]));
        end
        check_eq("any_rollover", 32'(any_rollover), 32'(any_exp));
    endtask

    // One clock: model predicts, edge happens, outputs compared 1 time unit later.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_ch(input int c, input bit clr, input bit ld, input int lv,
                          input bit en, input bit md, input int r);
        clear[c]              = clr;
        load[c]               = ld;
        load_val[c*W +: W]    = W'(lv);
        count_enable[c]       = en;
        mode[c]               = md;
        rollover_val[c*W +: W] = W'(r);
    endtask

    task automatic idle_all();
        for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic clear_all();
        for (int c = 0; c < NCH; c++) set_ch(c, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
        step();
        idle_all();
    endtask

    initial begin
        int seq2 [7] = '{1, 2, 3, 4, 5, 1, 2};
        int seq3 [5] = '{1, 2, 3, 3, 3};
        int pulses;

        rst = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_halt[c] = 1'b0; m_pulse[c] = 1'b0;
        end
        idle_all();
        #2;
        step();
        step();
        check_eq("reset_count", 32'(count_out), 32'd0);
        rst = 1'b0;
        step();

        // Wrap mode, R=5.
        set_ch(0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 5);
        for (int i = 0; i < 7; i++) begin
            step();
            check_eq("t2_seq", 32'(count_out[W-1:0]), 32'(seq2[i]));
            check_eq("t2_pulse", 32'(wrap_pulse[0]), 32'(seq2[i] == 5));
            check_eq("t2_flag", 32'(rollover_flag[0]), 32'(seq2[i] == 5));
        end

        // Reset held three cycles mid-count.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t1_count", 32'(count_out), 32'd0);
            check_eq("t1_pulse", 32'(wrap_pulse), 32'd0);
            check_eq("t1_any", 32'(any_rollover), 32'd0);
        end
        rst = 1'b0;

        // One-shot, R=3: single pulse then hold, clear resumes counting.
        set_ch(0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 3);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t3_seq", 32'(count_out[W-1:0]), 32'(seq3[i]));
            pulses += int'(wrap_pulse[0]);
        end
        check_eq("t3_pulses", 32'(pulses), 32'd1);
        clear[0] = 1'b1;
        step();
        check_eq("t3_clear", 32'(count_out[W-1:0]), 32'd0);
        clear[0] = 1'b0;
        step();
        check_eq("t3_resume", 32'(count_out[W-1:0]), 32'd1);

        // Priority and lowered terminal value.
        set_ch(0, 1'b1, 1'b1, 9, 1'b1, 1'b0, 4);
        step();
        check_eq("t4_clear_wins", 32'(count_out[W-1:0]), 32'd0);
        set_ch(0, 1'b0, 1'b1, 9, 1'b1, 1'b0, 4);
        step();
        check_eq("t4_load_wins", 32'(count_out[W-1:0]), 32'd9);
        set_ch(0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 4);
        step();
        check_eq("t4_past_r_wraps", 32'(count_out[W-1:0]), 32'd1);

        // R=0 parks at zero; R=15 reaches the top and wraps without overflow.
        set_ch(0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t5_zero_cnt", 32'(count_out[W-1:0]), 32'd0);
            check_eq("t5_zero_flag", 32'(rollover_flag[0]), 32'd0);
            check_eq("t5_zero_pulse", 32'(wrap_pulse[0]), 32'd0);
        end
        set_ch(0, 1'b0, 1'b1, 14, 1'b0, 1'b0, 15);
        step();
        set_ch(0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 15);
        step();
        check_eq("t5_top", 32'(count_out[W-1:0]), 32'd15);
        check_eq("t5_top_pulse", 32'(wrap_pulse[0]), 32'd1);
        step();
        check_eq("t5_wrap", 32'(count_out[W-1:0]), 32'd1);

        // Two channels: ch0 R=3, ch1 R=2, both enabled for six edges.
        clear_all();
        set_ch(0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 3);
        set_ch(1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 2);
        for (int i = 0; i < 6; i++) step();
`ifdef FLEX_CNT_CASCADE_EN
        check_eq("t6_ch1", 32'(count_out[W +: W]), 32'd1);
`else
        check_eq("t6_ch1", 32'(count_out[W +: W]), 32'd2);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int c = 0; c < NCH; c++) begin
                clear[c]        = ($urandom_range(0, 15) == 0);
                load[c]         = ($urandom_range(0, 15) == 0);
                load_val[c*W +: W] = W'($urandom_range(0, 15));
                count_enable[c] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 19) == 0) mode[c] = ~mode[c];
                if ($urandom_range(0, 15) == 0)
                    rollover_val[c*W +: W] = W'($urandom_range(0, 15));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_multi_flex_counter
